// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl
// Description : Multicycle control unit for the 8-bit accumulator CPU.
//               Sequences fetch / decode / address-operand fetch / execute,
//               with ADDR_BYTES address operand bytes and a mem_ready
//               handshake that stretches every memory-access state.
//               Optional macro HALT_ON_ILLEGAL_EN: an illegal opcode parks
//               the controller in HALT until reset (otherwise it acts as NOP).
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
    parameter int ADDR_BYTES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  z,
    input  logic [7:0]            opcode,
    input  logic                  mem_ready,
    output logic                  mem_req,
    output logic                  writeEnableAC,
    output logic                  writeEnableR,
    output logic                  writeEnableMem,
    output logic                  PCEnable,
    output logic                  instructionRegisterEnable,
    output logic                  dataRegisterEnable,
    output logic                  zeroEnable,
    output logic [ADDR_BYTES-1:0] addrByteEnable,
    output logic                  muxSelectPC,
    output logic                  muxSelectAddress,
    output logic                  muxSelectALUtoAC,
    output logic                  muxSelectMEM_or_R_toAC,
    output logic                  halted
);

    localparam int IDX_W = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(ADDR_BYTES - 1);

    localparam logic [3:0] c_FETCH  = 4'd0;
    localparam logic [3:0] c_DECODE = 4'd1;
    localparam logic [3:0] c_ALU    = 4'd2;
    localparam logic [3:0] c_MVAC   = 4'd3;
    localparam logic [3:0] c_MOVR   = 4'd4;
    localparam logic [3:0] c_ADDR   = 4'd5;
    localparam logic [3:0] c_STAC   = 4'd6;
    localparam logic [3:0] c_LDRD   = 4'd7;
    localparam logic [3:0] c_LDWR   = 4'd8;
    localparam logic [3:0] c_JUMP   = 4'd9;
    localparam logic [3:0] c_HALT   = 4'd10;

    localparam logic [3:0] c_OP_NOP  = 4'h0;
    localparam logic [3:0] c_OP_LDAC = 4'h1;
    localparam logic [3:0] c_OP_STAC = 4'h2;
    localparam logic [3:0] c_OP_MVAC = 4'h3;
    localparam logic [3:0] c_OP_MOVR = 4'h4;
    localparam logic [3:0] c_OP_JMPZ = 4'h6;
    localparam logic [3:0] c_OP_JPNZ = 4'h7;

    logic [3:0]       r_state;
    logic [3:0]       w_next_state;
    logic [IDX_W-1:0] r_idx;
    logic             w_illegal;
    logic             w_last_byte;
    logic             w_load;

    assign w_illegal   = |opcode[7:4];
    assign w_last_byte = (r_idx == c_LAST_IDX);
    // Register loads happen only in the completing cycle of an access, and
    // never while reset is held (reset parks us in FETCH, which would
    // otherwise load IR/PC when mem_ready happens to be high).
    assign w_load      = mem_ready & ~reset;

    // State register with asynchronous reset to FETCH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Address-operand byte index: cleared in DECODE, advanced per completed byte
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx <= '0;
        end else if (r_state == c_DECODE) begin
            r_idx <= '0;
        end else if ((r_state == c_ADDR) && mem_ready) begin
            r_idx <= w_last_byte ? '0 : r_idx + IDX_W'(1);
        end
    end

    // Next-state decode; memory states hold until mem_ready
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_FETCH: begin
                if (mem_ready) w_next_state = c_DECODE;
            end
            c_DECODE: begin
                if (w_illegal) begin
`ifdef HALT_ON_ILLEGAL_EN
                    w_next_state = c_HALT;
`else
                    w_next_state = c_FETCH;
`endif
                end else if (opcode[3]) begin
                    w_next_state = c_ALU;
                end else if (opcode[3:0] == c_OP_NOP) begin
                    w_next_state = c_FETCH;
                end else if (opcode[3:0] == c_OP_MVAC) begin
                    w_next_state = c_MVAC;
                end else if (opcode[3:0] == c_OP_MOVR) begin
                    w_next_state = c_MOVR;
                end else begin
                    w_next_state = c_ADDR;
                end
            end
            c_ADDR: begin
                // z is only looked at in the completing cycle of the last byte
                if (mem_ready && w_last_byte) begin
                    case (opcode[3:0])
                        c_OP_STAC: w_next_state = c_STAC;
                        c_OP_LDAC: w_next_state = c_LDRD;
                        c_OP_JMPZ: w_next_state = z ? c_JUMP : c_FETCH;
                        c_OP_JPNZ: w_next_state = z ? c_FETCH : c_JUMP;
                        default:   w_next_state = c_JUMP;
                    endcase
                end
            end
            c_STAC: begin
                if (mem_ready) w_next_state = c_FETCH;
            end
            c_LDRD: begin
                if (mem_ready) w_next_state = c_LDWR;
            end
            c_LDWR, c_ALU, c_MOVR, c_MVAC, c_JUMP: begin
                w_next_state = c_FETCH;
            end
            c_HALT: begin
                w_next_state = c_HALT;
            end
            default: begin
                w_next_state = c_FETCH;
            end
        endcase
    end

    // Datapath controls decoded from state, byte index and mem_ready
    always_comb begin
        mem_req                   = 1'b0;
        writeEnableAC             = 1'b0;
        writeEnableR              = 1'b0;
        writeEnableMem            = 1'b0;
        PCEnable                  = 1'b0;
        instructionRegisterEnable = 1'b0;
        dataRegisterEnable        = 1'b0;
        zeroEnable                = 1'b0;
        addrByteEnable            = '0;
        muxSelectPC               = 1'b1;
        muxSelectAddress          = 1'b0;
        muxSelectALUtoAC          = 1'b0;
        muxSelectMEM_or_R_toAC    = 1'b0;
        halted                    = 1'b0;
        case (r_state)
            c_FETCH: begin
                mem_req                   = 1'b1;
                muxSelectAddress          = 1'b1;
                instructionRegisterEnable = w_load;
                PCEnable                  = w_load;
            end
            c_ADDR: begin
                mem_req          = 1'b1;
                muxSelectAddress = 1'b1;
                PCEnable         = w_load;
                if (w_load) addrByteEnable = ADDR_BYTES'(1) << r_idx;
            end
            c_STAC: begin
                mem_req        = 1'b1;
                writeEnableMem = 1'b1;
            end
            c_LDRD: begin
                mem_req            = 1'b1;
                dataRegisterEnable = w_load;
            end
            c_LDWR: begin
                writeEnableAC = 1'b1;
                zeroEnable    = 1'b1;
            end
            c_ALU: begin
                writeEnableAC    = 1'b1;
                zeroEnable       = 1'b1;
                muxSelectALUtoAC = 1'b1;
            end
            c_MOVR: begin
                writeEnableAC          = 1'b1;
                zeroEnable             = 1'b1;
                muxSelectMEM_or_R_toAC = 1'b1;
            end
            c_MVAC: begin
                writeEnableR = 1'b1;
            end
            c_JUMP: begin
                PCEnable    = 1'b1;
                muxSelectPC = 1'b0;
            end
            c_HALT: begin
`ifdef HALT_ON_ILLEGAL_EN
                halted = 1'b1;
`endif
            end
            default: begin
                mem_req = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Parametrised multicycle control unit for the 8-bit accumulator CPU. It sequences fetch, decode, operand-address fetch and execute for the 16-instruction set, and drives every register enable, memory strobe and mux select in the datapath. It generalises the fixed two-byte-address, zero-wait-state controller in two ways: a configurable number of address operand bytes, and a memory ready handshake that stretches any memory-access state by wait states.

## Interface
Parameters:
- `ADDR_BYTES`, default 2: number of address operand bytes following LDAC/STAC/JUMP/JMPZ/JPNZ. Legal range 1..4.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `z`  in  1  zero flag register from datapath.
- `opcode`  in  8  instruction register contents.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `mem_req`  out  1  memory access in progress (read, or write when `writeEnableMem`=1).
- `writeEnableAC`, `writeEnableR`, `writeEnableMem`  out  1 each  AC, R and memory write enables.
- `PCEnable`, `instructionRegisterEnable`, `dataRegisterEnable`, `zeroEnable`  out  1 each  register load enables.
- `addrByteEnable`  out  ADDR_BYTES  one-hot load of address register byte; bit 0 is the MSB (first fetched).
- `muxSelectPC`  out  1  1 = PC+1, 0 = address register (jump).
- `muxSelectAddress`  out  1  1 = PC drives memory address, 0 = address register.
- `muxSelectALUtoAC`, `muxSelectMEM_or_R_toAC`  out  1 each  AC source selects.
- `halted`  out  1  controller stopped on illegal opcode (only with macro, else tied 0).

## Operation
- Opcode map (`opcode[7:4]` must be 0): 00 NOP, 01 LDAC, 02 STAC, 03 MVAC, 04 MOVR, 05 JUMP, 06 JMPZ, 07 JPNZ, 08–0F ALU ops (ADD, SUB, INAC, CLAC, AND, OR, XOR, NOT). Any nonzero upper nibble is illegal.
- States: FETCH, DECODE, ALU, MVAC, MOVR, ADDR, STAC, LDRD, LDWR, JUMP, HALT.
- Memory states are FETCH, ADDR, STAC and LDRD. In each one, `mem_req`=1 and the state holds until `mem_ready`=1. Load enables (`PCEnable`, `instructionRegisterEnable`, `addrByteEnable`, `dataRegisterEnable`) are asserted only in the cycle where `mem_ready`=1.
- FETCH: `muxSelectAddress`=1. On ready: load IR, increment PC, go to DECODE.
- DECODE routes as follows:
  - NOP → FETCH.
  - Illegal → NOP behaviour (or HALT with macro).
  - `opcode[3]`=1 → ALU.
  - MVAC → MVAC.
  - MOVR → MOVR.
  - Otherwise → ADDR with byte index `idx`=0.
- ADDR: `muxSelectAddress`=1. On ready: `addrByteEnable[idx]`=1, `PCEnable`=1, then `idx`++. After byte ADDR_BYTES-1 the next state is:
  - STAC → STAC.
  - LDAC → LDRD.
  - JMPZ with `z`=0, or JPNZ with `z`=1 → FETCH (not taken).
  - Otherwise → JUMP.
- STAC: `writeEnableMem`=1, `muxSelectAddress`=0 until ready → FETCH.
- LDRD: `muxSelectAddress`=0. On ready: `dataRegisterEnable`=1 → LDWR.
- LDWR / ALU / MOVR: one cycle each, with `writeEnableAC`=`zeroEnable`=1. LDWR selects memory data; ALU sets `muxSelectALUtoAC`=1; MOVR sets `muxSelectMEM_or_R_toAC`=1. All → FETCH.
- MVAC: `writeEnableR`=1 → FETCH.
- JUMP: `PCEnable`=1, `muxSelectPC`=0 → FETCH.
- Outputs are decoded from state, `idx` and `mem_ready` only. Mux selects not listed for a state take their default: `muxSelectPC`=1, others 0.

## Timing
- Reset (async) forces FETCH and `idx`=0. While reset is held or `mem_ready`=0: `mem_req`=1, `muxSelectAddress`=1, `muxSelectPC`=1, all enables 0, `halted`=0.
- Reset mid-operation abandons the instruction. `writeEnableMem` drops asynchronously, and no partial AC, R or memory write completes.
- Instruction cycle counts with `mem_ready` tied high; each wait cycle adds 1 per memory state:
  - NOP: 2.
  - ALU/MVAC/MOVR: 3.
  - JUMP/taken conditional: 3+ADDR_BYTES.
  - Untaken conditional: 2+ADDR_BYTES.
  - STAC: 3+ADDR_BYTES.
  - LDAC: 4+ADDR_BYTES.
- `z` is sampled in the final ADDR cycle, i.e. the cycle where `mem_ready`=1.
- `mem_ready` asserted outside a memory state is ignored.

## Configuration
- `HALT_ON_ILLEGAL_EN` defined: an illegal opcode in DECODE → HALT.
  - HALT asserts `halted`=1, all enables are 0, and `mem_req`=0.
  - It is exited only by reset.
- Macro undefined: an illegal opcode behaves as NOP, HALT is unreachable, and `halted` is constant 0.

## Test plan
- Reset, `mem_ready`=1, opcode 08 (ADD): FETCH, DECODE, ALU. `writeEnableAC`=`zeroEnable`=`muxSelectALUtoAC`=1 in cycle 3, then back to FETCH.
- ADDR_BYTES=2, opcode 01 (LDAC), `mem_ready`=1: `addrByteEnable` reads 01 then 10. `dataRegisterEnable` is high in cycle 5 and `writeEnableAC` in cycle 6.
- Opcode 02 (STAC) with `mem_ready` low for 3 cycles in the STAC state: `writeEnableMem`=1 and `mem_req`=1 for 4 cycles, then FETCH; total 8 cycles.
- Opcode 06 (JMPZ) with `z`=0 → FETCH after the address bytes, with no cycle where `muxSelectPC`=0. Repeat with `z`=1 → JUMP asserts `PCEnable`=1 and `muxSelectPC`=0.
- ADDR_BYTES=3, opcode 05 (JUMP): three one-hot `addrByteEnable` pulses (001, 010, 100); total 6 cycles.
- Opcode 0x1A:
  - Macro defined: `halted`=1 from cycle 3, persisting across 10 cycles until reset.
  - Macro undefined: returns to FETCH after 2 cycles.
